axi_grid_sni: RTL and testbench

- Subordinate-side grid network interface, i.e. the responder end of the grid.
- Accepts AW/W/AR flits addressed to NI_ID and forwards the AXI payload to a local AXI subordinate.
- Records each request's source id and returns the local B/R responses onto the grid with did = recorded sid and sid = NI_ID.
- Sits between a grid router port and one local subordinate.

---
 rtl/axi_default_param_pkg.sv | 47 ++++
 rtl/axi_grid_sid_fifo.sv | 61 ++++++
 rtl/axi_grid_sni.sv | 146 ++++++++++++++
 tb/tb_axi_grid_sni.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_default_param_pkg.sv
// Default grid/AXI payload types shared by the grid network interface blocks.
// Provides the grid node id type and the AW/W/B/AR/R channel payload structs.
package axi_default_param_pkg;

   localparam int unsigned GRID_ID_WIDTH = 4;
   localparam int unsigned AXI_ID_WIDTH  = 4;
   localparam int unsigned ADDR_WIDTH    = 32;
   localparam int unsigned DATA_WIDTH    = 32;
   localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8;

   typedef logic [GRID_ID_WIDTH-1:0] grid_id_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0] id;
      logic [ADDR_WIDTH-1:0]   addr;
      logic [7:0]              len;
      logic [2:0]              size;
      logic [1:0]              burst;
   } grid_aw_chan_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [STRB_WIDTH-1:0] strb;
      logic                  last;
   } grid_w_chan_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0] id;
      logic [1:0]              resp;
   } grid_b_chan_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0] id;
      logic [ADDR_WIDTH-1:0]   addr;
      logic [7:0]              len;
      logic [2:0]              size;
      logic [1:0]              burst;
   } grid_ar_chan_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0] id;
      logic [DATA_WIDTH-1:0]   data;
      logic [1:0]              resp;
      logic                    last;
   } grid_r_chan_t;

endpackage

// File: rtl/axi_grid_sid_fifo.sv
// Source-id FIFO: remembers the grid sid of each accepted request so the
// matching response can be routed back in order.
// Ports: clk_i/arst_ni, push/data_in (enqueue), pop/data_out (head),
//        full/empty (derived from the registered occupancy count).
module axi_grid_sid_fifo
   import axi_default_param_pkg::*;
#(
   parameter int unsigned DEPTH  = 8,
   parameter type         data_t = grid_id_t
) (
   input  logic  clk_i,
   input  logic  arst_ni,
   input  logic  push,
   input  data_t data_in,
   input  logic  pop,
   output data_t data_out,
   output logic  full,
   output logic  empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   data_t             r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_push;
   logic              w_pop;

   // Guard against overflow/underflow; DEPTH is a power of 2 so pointers wrap naturally.
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;

   assign full     = (r_count == CNT_W'(DEPTH));
   assign empty    = (r_count == '0);
   assign data_out = r_mem[r_rptr];

   // Storage has no reset; only pointers and count define validity.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= data_in;
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/axi_grid_sni.sv
// Subordinate-side grid network interface. Forwards AW/W/AR flits addressed
// to NI_ID to the local AXI subordinate (combinational, zero latency), drops
// misaddressed flits with a one-cycle misroute_o pulse, and returns B/R
// responses to the recorded requester (did = stored sid, sid = NI_ID).
// Ports: grid AW/W/AR in, grid B/R out, local m_* AXI master side,
//        misroute_o registered miss pulse.
module axi_grid_sni #(
   parameter type grid_id_t      = axi_default_param_pkg::grid_id_t,
   parameter type grid_aw_chan_t = axi_default_param_pkg::grid_aw_chan_t,
   parameter type grid_w_chan_t  = axi_default_param_pkg::grid_w_chan_t,
   parameter type grid_b_chan_t  = axi_default_param_pkg::grid_b_chan_t,
   parameter type grid_ar_chan_t = axi_default_param_pkg::grid_ar_chan_t,
   parameter type grid_r_chan_t  = axi_default_param_pkg::grid_r_chan_t,
   parameter grid_id_t    NI_ID              = '0,
   parameter int unsigned MAX_WR_OUTSTANDING = 8,
   parameter int unsigned MAX_RD_OUTSTANDING = 8
) (
   input  logic          clk_i,
   input  logic          arst_ni,
   input  grid_id_t      awdid_i,
   input  grid_id_t      awsid_i,
   input  grid_aw_chan_t awchan_i,
   input  logic          awvalid_i,
   output logic          awready_o,
   input  grid_id_t      wdid_i,
   input  grid_id_t      wsid_i,
   input  grid_w_chan_t  wchan_i,
   input  logic          wvalid_i,
   output logic          wready_o,
   input  grid_id_t      ardid_i,
   input  grid_id_t      arsid_i,
   input  grid_ar_chan_t archan_i,
   input  logic          arvalid_i,
   output logic          arready_o,
   output grid_id_t      bdid_o,
   output grid_id_t      bsid_o,
   output grid_b_chan_t  bchan_o,
   output logic          bvalid_o,
   input  logic          bready_i,
   output grid_id_t      rdid_o,
   output grid_id_t      rsid_o,
   output grid_r_chan_t  rchan_o,
   output logic          rvalid_o,
   input  logic          rready_i,
   output grid_aw_chan_t m_awchan_o,
   output logic          m_awvalid_o,
   input  logic          m_awready_i,
   output grid_w_chan_t  m_wchan_o,
   output logic          m_wvalid_o,
   input  logic          m_wready_i,
   input  grid_b_chan_t  m_bchan_i,
   input  logic          m_bvalid_i,
   output logic          m_bready_o,
   output grid_ar_chan_t m_archan_o,
   output logic          m_arvalid_o,
   input  logic          m_arready_i,
   input  grid_r_chan_t  m_rchan_i,
   input  logic          m_rvalid_i,
   output logic          m_rready_o,
   output logic          misroute_o
);

   logic     w_aw_hit, w_w_hit, w_ar_hit;
   logic     w_wr_full, w_wr_empty, w_rd_full, w_rd_empty;
   logic     w_wr_push, w_wr_pop, w_rd_push, w_rd_pop;
   logic     w_miss;
   grid_id_t w_wr_head, w_rd_head;
   logic     r_misroute;
   logic     w_unused_wsid;

   // W flits carry no tracked sid; keep the input visibly consumed.
   assign w_unused_wsid = ^wsid_i;

   assign w_aw_hit = (awdid_i == NI_ID);
   assign w_w_hit  = (wdid_i  == NI_ID);
   assign w_ar_hit = (ardid_i == NI_ID);

   // Request path: hits pass through, misses are always accepted and dropped.
   assign m_awchan_o  = awchan_i;
   assign m_awvalid_o = awvalid_i & w_aw_hit & ~w_wr_full;
   assign awready_o   = w_aw_hit ? (m_awready_i & ~w_wr_full) : 1'b1;
   assign w_wr_push   = awvalid_i & w_aw_hit & m_awready_i & ~w_wr_full;

   assign m_wchan_o   = wchan_i;
   assign m_wvalid_o  = wvalid_i & w_w_hit;
   assign wready_o    = w_w_hit ? m_wready_i : 1'b1;

   assign m_archan_o  = archan_i;
   assign m_arvalid_o = arvalid_i & w_ar_hit & ~w_rd_full;
   assign arready_o   = w_ar_hit ? (m_arready_i & ~w_rd_full) : 1'b1;
   assign w_rd_push   = arvalid_i & w_ar_hit & m_arready_i & ~w_rd_full;

   // Response path: held off while no requester is recorded.
   assign bvalid_o   = m_bvalid_i & ~w_wr_empty;
   assign m_bready_o = bready_i & ~w_wr_empty;
   assign bdid_o     = w_wr_head;
   assign bsid_o     = NI_ID;
   assign bchan_o    = m_bchan_i;
   assign w_wr_pop   = m_bvalid_i & bready_i & ~w_wr_empty;

   // Read bursts share one sid; release it only on the final beat.
   assign rvalid_o   = m_rvalid_i & ~w_rd_empty;
   assign m_rready_o = rready_i & ~w_rd_empty;
   assign rdid_o     = w_rd_head;
   assign rsid_o     = NI_ID;
   assign rchan_o    = m_rchan_i;
   assign w_rd_pop   = m_rvalid_i & rready_i & ~w_rd_empty & m_rchan_i.last;

   // Any misaddressed handshake this cycle.
   assign w_miss = (awvalid_i & ~w_aw_hit) | (wvalid_i & ~w_w_hit) | (arvalid_i & ~w_ar_hit);

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) r_misroute <= 1'b0;
      else          r_misroute <= w_miss;
   end
   assign misroute_o = r_misroute;

   axi_grid_sid_fifo #(
      .DEPTH  (MAX_WR_OUTSTANDING),
      .data_t (grid_id_t)
   ) u_wr_fifo (
      .clk_i    (clk_i),
      .arst_ni  (arst_ni),
      .push     (w_wr_push),
      .data_in  (awsid_i),
      .pop      (w_wr_pop),
      .data_out (w_wr_head),
      .full     (w_wr_full),
      .empty    (w_wr_empty)
   );

   axi_grid_sid_fifo #(
      .DEPTH  (MAX_RD_OUTSTANDING),
      .data_t (grid_id_t)
   ) u_rd_fifo (
      .clk_i    (clk_i),
      .arst_ni  (arst_ni),
      .push     (w_rd_push),
      .data_in  (arsid_i),
      .pop      (w_rd_pop),
      .data_out (w_rd_head),
      .full     (w_rd_full),
      .empty    (w_rd_empty)
   );

endmodule

// File: tb/tb_axi_grid_sni.sv
// Directed bench for axi_grid_sni with NI_ID = 5; the bench plays both the
// grid router and the local subordinate.
module tb_axi_grid_sni;
   import axi_default_param_pkg::*;

   logic clk = 1'b0;
   logic arst_ni;
   grid_id_t awdid_i, awsid_i, wdid_i, wsid_i, ardid_i, arsid_i;
   grid_aw_chan_t awchan_i, m_awchan_o;
   grid_w_chan_t  wchan_i, m_wchan_o;
   grid_ar_chan_t archan_i, m_archan_o;
   grid_b_chan_t  bchan_o, m_bchan_i;
   grid_r_chan_t  rchan_o, m_rchan_i;
   logic awvalid_i, awready_o, wvalid_i, wready_o, arvalid_i, arready_o;
   grid_id_t bdid_o, bsid_o, rdid_o, rsid_o;
   logic bvalid_o, bready_i, rvalid_o, rready_i;
   logic m_awvalid_o, m_awready_i, m_wvalid_o, m_wready_i;
   logic m_bvalid_i, m_bready_o, m_arvalid_o, m_arready_i;
   logic m_rvalid_i, m_rready_o, misroute_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   axi_grid_sni #(.NI_ID(4'd5), .MAX_WR_OUTSTANDING(8), .MAX_RD_OUTSTANDING(8)) dut (
      .clk_i(clk), .arst_ni(arst_ni),
      .awdid_i(awdid_i), .awsid_i(awsid_i), .awchan_i(awchan_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
      .wdid_i(wdid_i), .wsid_i(wsid_i), .wchan_i(wchan_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
      .ardid_i(ardid_i), .arsid_i(arsid_i), .archan_i(archan_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
      .bdid_o(bdid_o), .bsid_o(bsid_o), .bchan_o(bchan_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
      .rdid_o(rdid_o), .rsid_o(rsid_o), .rchan_o(rchan_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
      .m_awchan_o(m_awchan_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
      .m_wchan_o(m_wchan_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
      .m_bchan_i(m_bchan_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
      .m_archan_o(m_archan_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
      .m_rchan_i(m_rchan_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
      .misroute_o(misroute_o)
   );

   task automatic idle();
      awvalid_i = 1'b0; awdid_i = 4'd5; awsid_i = 4'd0; awchan_i = '0;
      wvalid_i  = 1'b0; wdid_i  = 4'd5; wsid_i  = 4'd0; wchan_i  = '0;
      arvalid_i = 1'b0; ardid_i = 4'd5; arsid_i = 4'd0; archan_i = '0;
      bready_i = 1'b1; rready_i = 1'b1;
      m_awready_i = 1'b1; m_wready_i = 1'b1; m_arready_i = 1'b1;
      m_bvalid_i = 1'b0; m_bchan_i = '0; m_rvalid_i = 1'b0; m_rchan_i = '0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push_aw(input logic [3:0] sid);
      awvalid_i = 1'b1; awdid_i = 4'd5; awsid_i = sid;
      tick();
      awvalid_i = 1'b0;
   endtask

   task automatic push_ar(input logic [3:0] sid, input logic [7:0] len);
      arvalid_i = 1'b1; ardid_i = 4'd5; arsid_i = sid; archan_i = '{id: 4'd1, addr: 32'h2000, len: len, size: 3'd2, burst: 2'd1};
      tick();
      arvalid_i = 1'b0;
   endtask

   task automatic test_reset();
      arst_ni = 1'b0; idle();
      m_bvalid_i = 1'b1; m_rvalid_i = 1'b1; m_rchan_i.last = 1'b1;
      #12;
      n_cmp++; if (bvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_bvalid got=%b exp=0", bvalid_o); end
      n_cmp++; if (rvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_rvalid got=%b exp=0", rvalid_o); end
      n_cmp++; if (m_bready_o !== 1'b0) begin n_err++; $display("FAIL rst_m_bready got=%b exp=0", m_bready_o); end
      n_cmp++; if (misroute_o !== 1'b0) begin n_err++; $display("FAIL rst_misroute got=%b exp=0", misroute_o); end
      @(negedge clk); arst_ni = 1'b1; idle();
      tick();
   endtask

   task automatic test_write();
      grid_aw_chan_t aw;
      grid_b_chan_t  b;
      aw = '{id: 4'd1, addr: 32'h1000, len: 8'd1, size: 3'd2, burst: 2'd1};
      awvalid_i = 1'b1; awdid_i = 4'd5; awsid_i = 4'd3; awchan_i = aw;
      #1;
      n_cmp++; if (m_awvalid_o !== 1'b1) begin n_err++; $display("FAIL wr_m_awvalid got=%b exp=1", m_awvalid_o); end
      n_cmp++; if (awready_o !== 1'b1) begin n_err++; $display("FAIL wr_awready got=%b exp=1", awready_o); end
      n_cmp++; if (m_awchan_o !== aw) begin n_err++; $display("FAIL wr_m_awchan got=%h exp=%h", m_awchan_o, aw); end
      tick(); awvalid_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wvalid_i = 1'b1; wdid_i = 4'd5; wchan_i = '{data: 32'hA0 + 32'(i), strb: 4'hF, last: (i == 1)};
         #1;
         n_cmp++; if (m_wvalid_o !== 1'b1 || wready_o !== 1'b1) begin n_err++; $display("FAIL wr_w_beat%0d got v=%b r=%b exp 1/1", i, m_wvalid_o, wready_o); end
         n_cmp++; if (m_wchan_o.data !== 32'hA0 + 32'(i)) begin n_err++; $display("FAIL wr_w_data got=%h exp=%h", m_wchan_o.data, 32'hA0 + 32'(i)); end
         tick();
      end
      wvalid_i = 1'b0;
      b = '{id: 4'd1, resp: 2'b00};
      m_bvalid_i = 1'b1; m_bchan_i = b;
      #1;
      n_cmp++; if (bvalid_o !== 1'b1) begin n_err++; $display("FAIL wr_bvalid got=%b exp=1", bvalid_o); end
      n_cmp++; if (bdid_o !== 4'd3) begin n_err++; $display("FAIL wr_bdid got=%0d exp=3", bdid_o); end
      n_cmp++; if (bsid_o !== 4'd5) begin n_err++; $display("FAIL wr_bsid got=%0d exp=5", bsid_o); end
      n_cmp++; if (bchan_o !== b) begin n_err++; $display("FAIL wr_bchan got=%h exp=%h", bchan_o, b); end
      n_cmp++; if (m_bready_o !== 1'b1) begin n_err++; $display("FAIL wr_m_bready got=%b exp=1", m_bready_o); end
      tick();
      n_cmp++; if (bvalid_o !== 1'b0 || m_bready_o !== 1'b0) begin n_err++; $display("FAIL wr_fifo_empty_after got v=%b r=%b exp 0/0", bvalid_o, m_bready_o); end
      m_bvalid_i = 1'b0;
   endtask

   task automatic test_read();
      push_ar(4'd2, 8'd3);
      push_ar(4'd7, 8'd0);
      m_rvalid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         m_rchan_i = '{id: 4'd1, data: 32'h100 + 32'(i), resp: 2'b00, last: (i == 3)};
         #1;
         n_cmp++; if (rvalid_o !== 1'b1 || rdid_o !== 4'd2) begin n_err++; $display("FAIL rd_beat%0d got v=%b did=%0d exp v=1 did=2", i, rvalid_o, rdid_o); end
         n_cmp++; if (rsid_o !== 4'd5 || rchan_o.data !== 32'h100 + 32'(i)) begin n_err++; $display("FAIL rd_beat%0d_payload got sid=%0d data=%h", i, rsid_o, rchan_o.data); end
         tick();
      end
      m_rchan_i = '{id: 4'd1, data: 32'h200, resp: 2'b00, last: 1'b1};
      #1;
      n_cmp++; if (rvalid_o !== 1'b1 || rdid_o !== 4'd7) begin n_err++; $display("FAIL rd_second got v=%b did=%0d exp v=1 did=7", rvalid_o, rdid_o); end
      tick();
      n_cmp++; if (rvalid_o !== 1'b0 || m_rready_o !== 1'b0) begin n_err++; $display("FAIL rd_empty_after got v=%b r=%b exp 0/0", rvalid_o, m_rready_o); end
      m_rvalid_i = 1'b0;
   endtask

   task automatic test_full();
      for (int s = 0; s < 8; s++) begin
         awvalid_i = 1'b1; awdid_i = 4'd5; awsid_i = 4'(s);
         #1;
         n_cmp++; if (awready_o !== 1'b1) begin n_err++; $display("FAIL full_fill%0d awready got=%b exp=1", s, awready_o); end
         tick();
      end
      awsid_i = 4'd8;
      m_bvalid_i = 1'b1; m_bchan_i = '{id: 4'd0, resp: 2'b00};
      #1;
      n_cmp++; if (awready_o !== 1'b0 || m_awvalid_o !== 1'b0) begin n_err++; $display("FAIL full_stall got r=%b v=%b exp 0/0", awready_o, m_awvalid_o); end
      n_cmp++; if (bdid_o !== 4'd0 || m_bready_o !== 1'b1) begin n_err++; $display("FAIL full_pop got did=%0d r=%b exp 0/1", bdid_o, m_bready_o); end
      tick();
      m_bvalid_i = 1'b0;
      #1;
      n_cmp++; if (awready_o !== 1'b1 || m_awvalid_o !== 1'b1) begin n_err++; $display("FAIL full_accept9 got r=%b v=%b exp 1/1", awready_o, m_awvalid_o); end
      tick();
      awvalid_i = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         m_bvalid_i = 1'b1;
         #1;
         n_cmp++; if (bdid_o !== 4'(k) || bvalid_o !== 1'b1) begin n_err++; $display("FAIL full_drain%0d got did=%0d v=%b exp did=%0d v=1", k, bdid_o, bvalid_o, k); end
         tick();
      end
      n_cmp++; if (m_bready_o !== 1'b0) begin n_err++; $display("FAIL full_drained got m_bready=%b exp=0", m_bready_o); end
      m_bvalid_i = 1'b0;
   endtask

   task automatic test_stall();
      grid_b_chan_t b;
      push_aw(4'd9);
      b = '{id: 4'd6, resp: 2'b10};
      bready_i = 1'b0; m_bvalid_i = 1'b1; m_bchan_i = b;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_cmp++; if (bvalid_o !== 1'b1 || bdid_o !== 4'd9 || bchan_o !== b || m_bready_o !== 1'b0) begin
            n_err++; $display("FAIL stall_c%0d got v=%b did=%0d ch=%h mr=%b exp v=1 did=9 ch=%h mr=0", c, bvalid_o, bdid_o, bchan_o, m_bready_o, b);
         end
         tick();
      end
      bready_i = 1'b1;
      #1;
      n_cmp++; if (m_bready_o !== 1'b1 || bdid_o !== 4'd9) begin n_err++; $display("FAIL stall_release got mr=%b did=%0d exp 1/9", m_bready_o, bdid_o); end
      tick();
      n_cmp++; if (bvalid_o !== 1'b0) begin n_err++; $display("FAIL stall_popped got v=%b exp=0", bvalid_o); end
      m_bvalid_i = 1'b0;
   endtask

   task automatic test_misroute();
      for (int ch = 0; ch < 3; ch++) begin
         case (ch)
            0: begin awvalid_i = 1'b1; awdid_i = 4'd4; awsid_i = 4'd1; end
            1: begin wvalid_i = 1'b1; wdid_i = 4'd4; end
            default: begin arvalid_i = 1'b1; ardid_i = 4'd4; arsid_i = 4'd1; end
         endcase
         #1;
         n_cmp++; if ((ch == 0 && (awready_o !== 1'b1 || m_awvalid_o !== 1'b0)) ||
                      (ch == 1 && (wready_o !== 1'b1 || m_wvalid_o !== 1'b0)) ||
                      (ch == 2 && (arready_o !== 1'b1 || m_arvalid_o !== 1'b0))) begin
            n_err++; $display("FAIL miss_ch%0d_consume got awr=%b wr=%b arr=%b", ch, awready_o, wready_o, arready_o);
         end
         n_cmp++; if (misroute_o !== 1'b0) begin n_err++; $display("FAIL miss_ch%0d_early got=%b exp=0", ch, misroute_o); end
         tick();
         idle();
         n_cmp++; if (misroute_o !== 1'b1) begin n_err++; $display("FAIL miss_ch%0d_pulse got=%b exp=1", ch, misroute_o); end
         tick();
         n_cmp++; if (misroute_o !== 1'b0) begin n_err++; $display("FAIL miss_ch%0d_one_cycle got=%b exp=0", ch, misroute_o); end
         m_bvalid_i = 1'b1; m_rvalid_i = 1'b1; m_rchan_i.last = 1'b1;
         #1;
         n_cmp++; if (bvalid_o !== 1'b0 || rvalid_o !== 1'b0) begin n_err++; $display("FAIL miss_ch%0d_no_push got bv=%b rv=%b exp 0/0", ch, bvalid_o, rvalid_o); end
         idle();
         tick();
      end
   endtask

   task automatic test_reset_mid();
      push_ar(4'd1, 8'd0);
      push_ar(4'd2, 8'd0);
      push_ar(4'd3, 8'd0);
      push_aw(4'd4);
      arvalid_i = 1'b1; ardid_i = 4'd4;
      tick();
      idle();
      m_bvalid_i = 1'b1; m_rvalid_i = 1'b1; m_rchan_i.last = 1'b1; bready_i = 1'b0; rready_i = 1'b0;
      #1;
      n_cmp++; if (rvalid_o !== 1'b1 || bvalid_o !== 1'b1 || misroute_o !== 1'b1) begin
         n_err++; $display("FAIL rstmid_pre got rv=%b bv=%b mis=%b exp 1/1/1", rvalid_o, bvalid_o, misroute_o);
      end
      #1 arst_ni = 1'b0;
      #1;
      n_cmp++; if (rvalid_o !== 1'b0 || bvalid_o !== 1'b0 || misroute_o !== 1'b0) begin
         n_err++; $display("FAIL rstmid_async got rv=%b bv=%b mis=%b exp 0/0/0", rvalid_o, bvalid_o, misroute_o);
      end
      @(negedge clk); arst_ni = 1'b1; bready_i = 1'b1; rready_i = 1'b1;
      tick();
      n_cmp++; if (rvalid_o !== 1'b0 || bvalid_o !== 1'b0 || m_rready_o !== 1'b0) begin
         n_err++; $display("FAIL rstmid_cleared got rv=%b bv=%b mr=%b exp 0/0/0", rvalid_o, bvalid_o, m_rready_o);
      end
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_full();
      test_stall();
      test_misroute();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
